zond_sequencer: RTL and testbench
=================================

Name: zond_sequencer

Overview:
- Per-frame scheduler for the 4 physical channels.
- On each main sync, runs a frame timer and fires 4 zond bursts (slots 0..3) and 4 data-acquisition starts (slots 0..3) at programmed delays.
- Channel routing for each slot comes from the zond/data order words.
- Sits between the control register block (static config) and the pulser/ADC capture logic.

Parameters:
- DLY_W, 24, width of delay fields and frame timer
- DIV_W, 8, width of frq_div / pulse_w

Ports:
- clk20  in  1  system clock
- res  in  1  synchronous active-high reset
- sync_in  in  1  main sync; single-cycle pulse starts a frame
- hv_en  in  1  high-voltage enable; 0 gates znd_out to 0 (timing still runs)
- znd_delay  in  4*DLY_W  slot k zond delay at [k*DLY_W +: DLY_W]
- data_delay  in  4*DLY_W  slot k acquisition delay, same packing
- num_order_z  in  8  slot k zond channel = [2k+1:2k]
- num_order_x  in  8  slot k data channel = [2k+1:2k]
- frq_div  in  DIV_W  pulse period minus 1, in clk20 cycles
- pulse_w  in  DIV_W  pulse high time, in clk20 cycles
- burst_n  in  4  pulses per burst (diag_data[3:0])
- znd_out  out  4  one-hot zond drive per physical channel
- acq_start  out  1  one-cycle acquisition start strobe
- acq_ch  out  2  channel for acq_start, valid when acq_start=1
- busy  out  1  frame in progress
- frame_done  out  1  one-cycle strobe at frame completion
- overrun  out  1  one-cycle strobe when sync_in arrives while busy

Behaviour:
- Reset (res=1 at clk20 edge):
  - all outputs 0
  - timer 0
  - zslot=0, xslot=0
  - state IDLE
- States: IDLE, RUN.
- IDLE:
  - On sync_in: timer<=0, zslot<=0, xslot<=0, busy<=1 next cycle, state RUN.
- RUN, timer:
  - timer increments by 1 each cycle.
  - Saturates at all-ones; no wrap.
- RUN, zond event:
  - Fires when burst generator idle, zslot<4, and timer >= znd_delay[zslot] (unsigned).
  - Action: start burst on channel num_order_z[2*zslot+:2]; zslot++.
  - Out-of-order or small delays therefore fire immediately after the preceding burst completes; slots never overlap.
- RUN, data event:
  - Fires when xslot<4 and timer >= data_delay[xslot].
  - Action: acq_start=1, acq_ch=num_order_x[2*xslot+:2] on the next cycle; xslot++.
  - At most one data event per cycle; it is independent of zond events, and both may fire in the same cycle.
- Burst generator:
  - Loads N=burst_n, P=frq_div+1, W=pulse_w at start.
  - znd_out[ch] goes high 1 cycle after the fire decision.
  - Within each period, high while phase<W.
  - Idle after N*P cycles.
  - N=0: idle the following cycle, no pulse.
  - W=0: no high time.
  - W>=P: high continuously for the whole burst.
  - znd_out = one-hot(ch) & {4{hv_en & high}}.
  - Config inputs sampled only at burst start; changes mid-burst have no effect.
- Completion:
  - When zslot==4, xslot==4 and burst idle: frame_done=1 for one cycle, busy<=0, state IDLE.
  - timer holds its value until the next sync.
- sync_in while RUN:
  - overrun=1 for one cycle.
  - Active burst aborted: znd_out 0 next cycle.
  - Frame restarts: timer=0, slots=0, no frame_done.
- sync_in coinciding with completion cycle: completion takes priority; frame_done=1, and the new frame starts the same cycle with no overrun.
- Reset mid-frame: immediate return to reset state, including during a burst.

Decomposition:
- Shared package zond_pkg holds:
  - NSLOT=4, CH_W=2
  - state enum {IDLE, RUN}
  - field-extract functions for the packed delay and order words
- One sub-module: zond_burst_gen, containing the period/width/count counters, start/idle handshake and abort input.

Test Plan:
- Defaults (znd_delay 0/4000/8000/1200, data_delay 0/4000/8000/12000, orders 8'hE4, frq_div=49, pulse_w=25, burst_n=4, hv_en=1) + sync:
  - znd_out[0] high 1 cycle after sync+1; 4 pulses, 25 high / 25 low each.
  - Ch1 burst at timer 4000, ch2 at 8000.
  - Ch3 burst immediately after ch2 burst ends (timer 8200).
  - acq_start at 0/4000/8000/12000 with acq_ch 0/1/2/3.
  - frame_done at timer 12000+1.
- num_order_z=8'h1B: bursts appear on channels 3,2,1,0 in order.
- hv_en=0: znd_out stays 0 for the whole frame; acq_start timing and frame_done are identical to the default case.
- burst_n=0, all delays 0: all four zond slots consume one cycle each with no pulses; 4 acq_start strobes on consecutive cycles; frame_done follows.
- Second sync at timer 5000: overrun=1 for one cycle; active burst cut; acq_ch sequence restarts at 0; no frame_done.
- pulse_w=60, frq_div=49, burst_n=2: znd_out high continuously for 100 cycles.
- res asserted mid-burst: all outputs 0 next cycle; busy=0.

Source files
------------

// File: rtl/zond_pkg.sv
// Shared definitions for the zond frame sequencer.
// Slot/channel sizing, the sequencer state type and helpers that pull one
// slot's field out of the packed delay and channel-order words.
package zond_pkg;
  localparam int NSLOT     = 4;   // zond / acquisition slots per frame
  localparam int NCH       = 4;   // physical channels
  localparam int CH_W      = 2;
  localparam int SLOT_W    = 3;   // slot counters run 0..NSLOT
  localparam int BN_W      = 4;   // pulses-per-burst field
  localparam int MAX_DLY_W = 32;  // widest delay field the extractor handles
  localparam int PK_W      = NSLOT * MAX_DLY_W;

  localparam logic [SLOT_W-1:0] SLOT_END = SLOT_W'(NSLOT);

  typedef enum logic {IDLE, RUN} state_t;

  // Channel of slot k from an order word (slot k at [2k+1:2k]).
  function automatic logic [CH_W-1:0] order_ch(input logic [NSLOT*CH_W-1:0] w,
                                               input logic [SLOT_W-1:0] k);
    return w[int'(k[1:0])*CH_W +: CH_W];
  endfunction

  // Delay of slot k from a packed delay word whose fields are 'width' bits
  // wide. The caller zero-extends the word to PK_W; the result is
  // zero-extended to MAX_DLY_W so it can be compared against a widened timer.
  function automatic logic [MAX_DLY_W-1:0] dly_field(input logic [PK_W-1:0] w,
                                                     input int width,
                                                     input logic [SLOT_W-1:0] k);
    logic [MAX_DLY_W-1:0] r;
    r = '0;
    for (int b = 0; b < MAX_DLY_W; b++)
      if (b < width) r[b] = w[int'(k[1:0])*width + b];
    return r;
  endfunction
endpackage

// File: rtl/zond_sequencer_if.sv
// Sequencer bus: frame sync, static configuration from the register block,
// and the pulser / acquisition-side outputs.
//   master : control side (drives sync and config, observes status)
//   slave  : the sequencer
interface zond_sequencer_if
  import zond_pkg::*;
#(
  parameter int DLY_W = 24,
  parameter int DIV_W = 8
);
  logic                   sync_in;
  logic                   hv_en;
  logic [NSLOT*DLY_W-1:0] znd_delay;
  logic [NSLOT*DLY_W-1:0] data_delay;
  logic [NSLOT*CH_W-1:0]  num_order_z;
  logic [NSLOT*CH_W-1:0]  num_order_x;
  logic [DIV_W-1:0]       frq_div;
  logic [DIV_W-1:0]       pulse_w;
  logic [BN_W-1:0]        burst_n;
  logic [NCH-1:0]         znd_out;
  logic                   acq_start;
  logic [CH_W-1:0]        acq_ch;
  logic                   busy;
  logic                   frame_done;
  logic                   overrun;

  modport master (
    output sync_in, hv_en, znd_delay, data_delay, num_order_z, num_order_x,
           frq_div, pulse_w, burst_n,
    input  znd_out, acq_start, acq_ch, busy, frame_done, overrun
  );

  modport slave (
    input  sync_in, hv_en, znd_delay, data_delay, num_order_z, num_order_x,
           frq_div, pulse_w, burst_n,
    output znd_out, acq_start, acq_ch, busy, frame_done, overrun
  );
endinterface

// File: rtl/zond_burst_gen.sv
// Burst generator: on start, emits n pulses of period frq_div+1 and high time
// pulse_w on one channel, starting the cycle after start.
//   clk20, res : clock, synchronous active-high reset
//   start      : load config and begin a burst (only honoured when idle)
//   abort      : kill the current burst; output drops next cycle
//   ch, n, frq_div, pulse_w : burst config, sampled only at start
//   hv_en      : gates the drive output
//   idle       : a new burst may start this cycle
//   znd_out    : one-hot channel drive
module zond_burst_gen
  import zond_pkg::*;
#(
  parameter int DIV_W = 8
) (
  input  logic             clk20,
  input  logic             res,
  input  logic             start,
  input  logic             abort,
  input  logic [CH_W-1:0]  ch,
  input  logic [BN_W-1:0]  n,
  input  logic [DIV_W-1:0] frq_div,
  input  logic [DIV_W-1:0] pulse_w,
  input  logic             hv_en,
  output logic             idle,
  output logic [NCH-1:0]   znd_out
);
  // Registers describe the cycle currently being driven.
  logic             act;
  logic [DIV_W-1:0] ph, p_m1, w;
  logic [BN_W-1:0]  n_left;
  logic [CH_W-1:0]  ch_q;
  logic             last;

  // The final cycle of a burst already counts as idle, so the next burst can
  // be launched back-to-back without a gap.
  assign last = act && (ph == p_m1) && (n_left == BN_W'(1));
  assign idle = !act || last;

  always_ff @(posedge clk20) begin
    if (res) begin
      act    <= 1'b0;
      ph     <= '0;
      p_m1   <= '0;
      w      <= '0;
      n_left <= '0;
      ch_q   <= '0;
    end else if (abort) begin
      act <= 1'b0;
    end else if (start) begin
      act    <= (n != '0);
      ph     <= '0;
      p_m1   <= frq_div;
      w      <= pulse_w;
      n_left <= n;
      ch_q   <= ch;
    end else if (act) begin
      if (ph == p_m1) begin
        ph     <= '0;
        n_left <= n_left - 1'b1;
        if (n_left == BN_W'(1)) act <= 1'b0;
      end else begin
        ph <= ph + 1'b1;
      end
    end
  end

  // ph < w for every phase when w > frq_div, giving a continuous burst.
  assign znd_out = (act && hv_en && (ph < w)) ? (NCH'(1) << ch_q) : '0;
endmodule

// File: rtl/zond_sequencer.sv
// Per-frame scheduler for the four physical channels. A sync pulse starts a
// frame timer; four zond bursts and four acquisition starts are fired at
// their programmed delays, routed through the order words.
//   clk20, res : clock, synchronous active-high reset
//   bus        : sync, config, zond drive, acq strobe/channel, busy,
//                frame_done and overrun strobes
module zond_sequencer
  import zond_pkg::*;
#(
  parameter int DLY_W = 24,
  parameter int DIV_W = 8
) (
  input  logic           clk20,
  input  logic           res,
  zond_sequencer_if.slave bus
);
  state_t               state;
  logic [DLY_W-1:0]     timer;
  logic [SLOT_W-1:0]    zslot, xslot;
  logic                 busy, frame_done, overrun, acq_start;
  logic [CH_W-1:0]      acq_ch;
  logic                 bg_idle, bg_start, bg_abort;
  logic [MAX_DLY_W-1:0] timer_x, zd_cur, xd_cur;
  logic                 z_fire, x_fire, done;

  assign timer_x = MAX_DLY_W'(timer);
  assign zd_cur  = dly_field(PK_W'(bus.znd_delay),  DLY_W, zslot);
  assign xd_cur  = dly_field(PK_W'(bus.data_delay), DLY_W, xslot);

  // Late slots (delay already passed) fire as soon as the generator frees up.
  assign z_fire = (state == RUN) && bg_idle && (zslot < SLOT_END) && (timer_x >= zd_cur);
  assign x_fire = (state == RUN) && (xslot < SLOT_END) && (timer_x >= xd_cur);
  assign done   = (state == RUN) && (zslot == SLOT_END) && (xslot == SLOT_END) && bg_idle;

  // A sync in the completion cycle is a clean restart, not an overrun.
  assign bg_start = z_fire && !bus.sync_in;
  assign bg_abort = (state == RUN) && bus.sync_in && !done;

  zond_burst_gen #(.DIV_W(DIV_W)) u_burst (
    .clk20   (clk20),
    .res     (res),
    .start   (bg_start),
    .abort   (bg_abort),
    .ch      (order_ch(bus.num_order_z, zslot)),
    .n       (bus.burst_n),
    .frq_div (bus.frq_div),
    .pulse_w (bus.pulse_w),
    .hv_en   (bus.hv_en),
    .idle    (bg_idle),
    .znd_out (bus.znd_out)
  );

  always_ff @(posedge clk20) begin
    if (res) begin
      state      <= IDLE;
      timer      <= '0;
      zslot      <= '0;
      xslot      <= '0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      overrun    <= 1'b0;
      acq_start  <= 1'b0;
      acq_ch     <= '0;
    end else begin
      frame_done <= done;
      overrun    <= 1'b0;
      acq_start  <= 1'b0;
      if (done) begin
        state <= IDLE;
        busy  <= 1'b0;
      end
      if (bus.sync_in) begin
        overrun <= bg_abort;
        state   <= RUN;
        busy    <= 1'b1;
        timer   <= '0;
        zslot   <= '0;
        xslot   <= '0;
      end else if (state == RUN && !done) begin
        if (timer != '1) timer <= timer + 1'b1;
        if (z_fire) zslot <= zslot + 1'b1;
        if (x_fire) begin
          xslot     <= xslot + 1'b1;
          acq_start <= 1'b1;
          acq_ch    <= order_ch(bus.num_order_x, xslot);
        end
      end
    end
  end

  assign bus.busy       = busy;
  assign bus.frame_done = frame_done;
  assign bus.overrun    = overrun;
  assign bus.acq_start  = acq_start;
  assign bus.acq_ch     = acq_ch;
endmodule

// File: tb/tb_zond_sequencer.sv
// Bench for zond_sequencer: a frame-plan model computes, at each sync, when
// every burst and acquisition strobe must happen; a per-cycle compare checks
// all outputs against it, and directed scenarios pin key cycles by hand.
module tb_zond_sequencer;
  import zond_pkg::*;
  localparam int DLY_W = 24;
  localparam int DIV_W = 8;

  logic clk20 = 1'b0;
  logic res   = 1'b1;
  zond_sequencer_if #(.DLY_W(DLY_W), .DIV_W(DIV_W)) bus ();
  zond_sequencer #(.DLY_W(DLY_W), .DIV_W(DIV_W)) dut (.clk20(clk20), .res(res), .bus(bus));

  always #5 clk20 = ~clk20;

  int vectors = 0, miscompares = 0;
  int cyc = 0;
  bit chk_en = 1'b0;
  int zdly[4], xdly[4];

  // frame plan (times are timer values relative to the frame's first cycle)
  bit         plan = 1'b0;
  int         f0, m_bn, m_p, m_w, m_t;
  int         m_zd[4], m_xa[4];
  logic [1:0] m_zc[4], m_xc[4];
  int         done_carry = -1, ovr_at = -1;

  always @(negedge clk20) begin
    logic [3:0] ez;
    logic       ea, eb, ed, eo;
    logic [1:0] ec;
    logic [9:0] got, want;
    int r, tf, pv, d;
    ez = '0; ea = 0; ec = '0; eb = 0; ed = 0; eo = 0;
    if (plan) begin
      r = cyc - f0;
      for (int k = 0; k < 4; k++)
        if (m_bn > 0 && r > m_zd[k] && r <= m_zd[k] + m_bn*m_p &&
            ((r - m_zd[k] - 1) % m_p) < m_w && bus.hv_en)
          ez[m_zc[k]] = 1'b1;
      for (int k = 0; k < 4; k++)
        if (r == m_xa[k] + 1) begin ea = 1'b1; ec = m_xc[k]; end
      eb = (r <= m_t);
      ed = (r == m_t + 1);
    end
    if (cyc == done_carry) ed = 1'b1;
    if (cyc == ovr_at) eo = 1'b1;
    if (chk_en) begin
      got  = {bus.znd_out, bus.acq_start, bus.acq_start ? bus.acq_ch : 2'b00,
              bus.busy, bus.frame_done, bus.overrun};
      want = {ez, ea, ec, eb, ed, eo};
      vectors++;
      if (got !== want) begin
        miscompares++;
        $display("FAIL cycle %0d outputs {znd,acq,ch,busy,done,ovr}: got %b want %b", cyc, got, want);
      end
    end
    // model update for the inputs sampled at the coming edge
    if (res) begin
      plan = 1'b0; done_carry = -1; ovr_at = -1;
    end else if (bus.sync_in) begin
      if (plan && cyc - f0 == m_t) done_carry = cyc + 1;
      else if (plan && cyc - f0 < m_t) ovr_at = cyc + 1;
      plan = 1'b1;
      f0   = cyc + 1;
      m_bn = int'(bus.burst_n);
      m_p  = int'(bus.frq_div) + 1;
      m_w  = int'(bus.pulse_w);
      tf = 0;
      for (int k = 0; k < 4; k++) begin
        d = int'(bus.znd_delay[k*DLY_W +: DLY_W]);
        if (d < tf) d = tf;
        m_zd[k] = d;
        m_zc[k] = bus.num_order_z[2*k +: 2];
        tf = d + ((m_bn == 0) ? 1 : m_bn*m_p);
      end
      pv = -1;
      for (int k = 0; k < 4; k++) begin
        d = int'(bus.data_delay[k*DLY_W +: DLY_W]);
        if (d < pv + 1) d = pv + 1;
        m_xa[k] = d;
        m_xc[k] = bus.num_order_x[2*k +: 2];
        pv = d;
      end
      m_t = (tf > pv + 1) ? tf : pv + 1;
    end
    cyc++;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk20);
    #1;
  endtask

  task automatic goto(input int c);
    while (cyc < c) tick(1);
  endtask

  task automatic lit(input string nm, input logic [31:0] got, input logic [31:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s: got %0h want %0h", nm, got, want);
    end
  endtask

  task automatic push();
    logic [4*DLY_W-1:0] zv, xv;
    for (int k = 0; k < 4; k++) begin
      zv[k*DLY_W +: DLY_W] = DLY_W'(zdly[k]);
      xv[k*DLY_W +: DLY_W] = DLY_W'(xdly[k]);
    end
    bus.znd_delay  = zv;
    bus.data_delay = xv;
  endtask

  task automatic defaults();
    zdly = '{0, 4000, 8000, 1200};
    xdly = '{0, 4000, 8000, 12000};
    push();
    bus.num_order_z = 8'hE4; bus.num_order_x = 8'hE4;
    bus.frq_div = 8'd49; bus.pulse_w = 8'd25; bus.burst_n = 4'd4; bus.hv_en = 1'b1;
  endtask

  task automatic sync_pulse(output int fs);
    bus.sync_in = 1'b1;
    fs = cyc + 1;
    tick(1);
    bus.sync_in = 1'b0;
  endtask

  initial begin
    int fs, fs2;
    bus.sync_in = 1'b0;
    defaults();
    tick(3);
    lit("reset znd_out", 32'(bus.znd_out), 0);
    lit("reset busy/acq/done/ovr", {bus.busy, bus.acq_start, bus.frame_done, bus.overrun}, 0);
    chk_en = 1'b1;
    res = 1'b0;
    tick(2);

    // default frame
    sync_pulse(fs);
    goto(fs + 1);     lit("dflt znd r1", 32'(bus.znd_out), 4'b0001);
                      lit("dflt acq0", {bus.acq_start, bus.acq_ch}, 3'b100);
    goto(fs + 25);    lit("dflt znd r25", 32'(bus.znd_out), 4'b0001);
    goto(fs + 26);    lit("dflt znd r26 low", 32'(bus.znd_out), 0);
    goto(fs + 151);   lit("dflt pulse4 start", 32'(bus.znd_out), 4'b0001);
    goto(fs + 201);   lit("dflt burst0 end", 32'(bus.znd_out), 0);
    goto(fs + 4001);  lit("dflt ch1 burst", 32'(bus.znd_out), 4'b0010);
                      lit("dflt acq1", {bus.acq_start, bus.acq_ch}, 3'b101);
    goto(fs + 8201);  lit("dflt ch3 after ch2", 32'(bus.znd_out), 4'b1000);
    goto(fs + 12001); lit("dflt acq3", {bus.acq_start, bus.acq_ch, bus.busy}, 4'b1111);
    goto(fs + 12002); lit("dflt frame_done", {bus.frame_done, bus.busy}, 2'b10);
    goto(fs + 12005);

    // hv_en low: timing unchanged, no drive
    bus.hv_en = 1'b0;
    sync_pulse(fs);
    goto(fs + 1);     lit("hv0 znd", 32'(bus.znd_out), 0);
    goto(fs + 12002); lit("hv0 frame_done", 32'(bus.frame_done), 1);
    goto(fs + 12004);
    bus.hv_en = 1'b1;

    // empty bursts, zero delays; second sync lands on the completion cycle
    bus.burst_n = 4'd0; zdly = '{0, 0, 0, 0}; xdly = '{0, 0, 0, 0}; push();
    sync_pulse(fs);
    goto(fs + 1);     lit("bn0 acq0", {bus.acq_start, bus.acq_ch}, 3'b100);
    goto(fs + 4);     lit("bn0 acq3", {bus.acq_start, bus.acq_ch}, 3'b111);
    sync_pulse(fs2);
    lit("bn0 done+restart", {bus.frame_done, bus.overrun, bus.busy}, 3'b101);
    goto(fs2 + 5);    lit("bn0 2nd frame_done", 32'(bus.frame_done), 1);
    goto(fs2 + 8);

    // pulse_w >= period: continuous drive, bursts back-to-back
    bus.burst_n = 4'd2; bus.pulse_w = 8'd60;
    sync_pulse(fs);
    goto(fs + 1);     lit("wide r1", 32'(bus.znd_out), 4'b0001);
    goto(fs + 50);    lit("wide r50", 32'(bus.znd_out), 4'b0001);
    goto(fs + 100);   lit("wide r100", 32'(bus.znd_out), 4'b0001);
    goto(fs + 101);   lit("wide next slot", 32'(bus.znd_out), 4'b0010);
    goto(fs + 401);   lit("wide frame_done", 32'(bus.frame_done), 1);
    goto(fs + 404);

    // overrun mid-burst
    defaults(); zdly[1] = 4900; push();
    sync_pulse(fs);
    goto(fs + 4910);  lit("ovr burst active", 32'(bus.znd_out), 4'b0010);
    goto(fs + 5000);
    sync_pulse(fs2);
    lit("ovr strobe", {bus.overrun, bus.busy, bus.frame_done}, 3'b110);
    lit("ovr burst cut", 32'(bus.znd_out), 0);
    goto(fs2 + 1);    lit("ovr restart acq0", {bus.acq_start, bus.acq_ch, bus.overrun}, 4'b1000);
    goto(fs2 + 12002); lit("ovr later frame_done", 32'(bus.frame_done), 1);
    goto(fs2 + 12004);

    // reversed order, then reset during a burst
    defaults(); bus.num_order_z = 8'h1B;
    sync_pulse(fs);
    goto(fs + 1);     lit("1B slot0 ch3", 32'(bus.znd_out), 4'b1000);
    goto(fs + 4001);  lit("1B slot1 ch2", 32'(bus.znd_out), 4'b0100);
    goto(fs + 8001);  lit("1B slot2 ch1", 32'(bus.znd_out), 4'b0010);
    goto(fs + 8210);  lit("1B slot3 ch0", 32'(bus.znd_out), 4'b0001);
    res = 1'b1;
    tick(1);
    lit("res znd_out", 32'(bus.znd_out), 0);
    lit("res busy/acq/done/ovr", {bus.busy, bus.acq_start, bus.frame_done, bus.overrun}, 0);
    tick(2);
    res = 1'b0;
    tick(5);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
